// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Helpers shared by the FIFO family: ceil-log2, pointer
//                width derivation and threshold range checking.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

   // Ceiling log2. A value of 0 or 1 gives 0.
   function automatic int clog2(input int n);
      int r;
      int v;
      r = 0;
      v = 1;
      while (v < n) begin
         v = v * 2;
         r = r + 1;
      end
      return r;
   endfunction

   // Pointers carry one bit above the address so that full and empty can be
   // told apart when the address bits are equal.
   function automatic int ptr_width(input int depth);
      return clog2(depth) + 1;
   endfunction

   // Thresholds must sit inside the range the occupancy count can reach.
   function automatic bit thresh_ok(input int af, input int ae, input int depth);
      return (af >= 1) && (af <= depth) && (ae >= 0) && (ae <= depth - 1);
   endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_mem
//  Description : DEPTH x DATA_W storage array with a synchronous write port
//                and an asynchronous read port. Contents are not reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_mem #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   localparam int c_DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] r_mem [0:c_DEPTH-1];

   // Write the addressed entry on the rising edge when enabled.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         r_mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = r_mem[rd_addr];

endmodule : fifo_mem
`default_nettype wire

// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_param
//  Description : Parametrised single-clock FIFO with programmable almost
//                thresholds, occupancy count, synchronous flush, registered
//                overflow/underflow pulses, sticky error flag and selectable
//                standard or first-word-fall-through read mode.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_param
   import fifo_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 4,
   parameter int AF_THRESH = 14,
   parameter int AE_THRESH = 2,
   parameter int FWFT      = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              push,
   input  logic [DATA_W-1:0] data_in,
   input  logic              pop,
   output logic [DATA_W-1:0] data_out,
   output logic              rd_valid,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   output logic              underflow,
   input  logic              clr_err,
   output logic              err_sticky
);

   localparam int                 c_DEPTH = 1 << ADDR_W;
   localparam int                 c_PTR_W = ptr_width(c_DEPTH);
   localparam logic [c_PTR_W-1:0] c_ONE   = c_PTR_W'(1);
   localparam logic [c_PTR_W-1:0] c_AF    = c_PTR_W'(AF_THRESH);
   localparam logic [c_PTR_W-1:0] c_AE    = c_PTR_W'(AE_THRESH);

   // Out-of-range thresholds would make almost_full/almost_empty meaningless.
   if (!thresh_ok(AF_THRESH, AE_THRESH, c_DEPTH)) begin : g_param_check
      $error("sync_fifo_param: AF_THRESH/AE_THRESH outside valid range");
   end

   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_PTR_W-1:0] w_count;
   logic               w_full;
   logic               w_empty;
   logic               w_push_acc;
   logic               w_pop_acc;
   logic               w_ovf;
   logic               w_unf;
   logic               r_ovf;
   logic               r_unf;
   logic               r_err;
   logic [DATA_W-1:0]  w_rd_data;

   // Status is decoded purely from the registered pointers.
   assign w_count = r_wr_ptr - r_rd_ptr;
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[c_PTR_W-2:0] == r_rd_ptr[c_PTR_W-2:0]) &&
                    (r_wr_ptr[c_PTR_W-1]   != r_rd_ptr[c_PTR_W-1]);

   // A push into a full FIFO still goes through when a pop frees the slot
   // in the same cycle, so a full FIFO keeps streaming at one word/cycle.
   assign w_pop_acc  = pop  && !flush && !w_empty;
   assign w_push_acc = push && !flush && (!w_full || w_pop_acc);
   assign w_ovf      = push && !flush && !w_push_acc;
   assign w_unf      = pop  && !flush && w_empty;

   // Pointer update; flush overrides any push/pop in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push_acc) r_wr_ptr <= r_wr_ptr + c_ONE;
         if (w_pop_acc)  r_rd_ptr <= r_rd_ptr + c_ONE;
      end
   end

   // Error pulses for one cycle; sticky flag holds until cleared, with a
   // same-cycle error taking precedence over the clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ovf <= 1'b0;
         r_unf <= 1'b0;
         r_err <= 1'b0;
      end else begin
         r_ovf <= w_ovf;
         r_unf <= w_unf;
         if (w_ovf || w_unf) begin
            r_err <= 1'b1;
         end else if (clr_err) begin
            r_err <= 1'b0;
         end
      end
   end

   fifo_mem #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk     (clk),
      .wr_en   (w_push_acc),
      .wr_addr (r_wr_ptr[c_PTR_W-2:0]),
      .wr_data (data_in),
      .rd_addr (r_rd_ptr[c_PTR_W-2:0]),
      .rd_data (w_rd_data)
   );

   if (FWFT != 0) begin : g_fwft
      // Head entry is presented directly; pop only acknowledges it.
      assign data_out = w_rd_data;
      assign rd_valid = !w_empty;
   end else begin : g_std
      logic [DATA_W-1:0] r_dout;
      logic              r_rd_valid;

      // Registered read: capture the head word on each accepted pop.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_dout     <= '0;
            r_rd_valid <= 1'b0;
         end else if (flush) begin
            r_rd_valid <= 1'b0;
         end else begin
            r_rd_valid <= w_pop_acc;
            if (w_pop_acc) r_dout <= w_rd_data;
         end
      end

      assign data_out = r_dout;
      assign rd_valid = r_rd_valid;
   end

   assign full         = w_full;
   assign empty        = w_empty;
   assign count        = w_count;
   assign almost_full  = (w_count >= c_AF);
   assign almost_empty = (w_count <= c_AE);
   assign overflow     = r_ovf;
   assign underflow    = r_unf;
   assign err_sticky   = r_err;

endmodule : sync_fifo_param
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sync_fifo_param
//  Description : Directed self-checking bench for sync_fifo_param, covering
//                the standard-read default configuration and a 16-bit,
//                depth-8 FWFT configuration.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_param;

   logic       clk = 1'b0;
   logic       rst;
   int         vectors = 0;
   int         errors  = 0;

   // Standard-mode instance (default parameters)
   logic       flush, push, pop, clr_err;
   logic [7:0] din, dout;
   logic       rd_valid, full, empty, afull, aempty, ovf, unf, err;
   logic [4:0] count;

   // FWFT instance
   logic        f_flush, f_push, f_pop, f_clr_err;
   logic [15:0] f_din, f_dout;
   logic        f_rd_valid, f_full, f_empty, f_afull, f_aempty, f_ovf, f_unf, f_err;
   logic [3:0]  f_count;

   always #5 clk = ~clk;

   sync_fifo_param dut (
      .clk(clk), .rst(rst), .flush(flush), .push(push), .data_in(din),
      .pop(pop), .data_out(dout), .rd_valid(rd_valid), .full(full),
      .empty(empty), .almost_full(afull), .almost_empty(aempty),
      .count(count), .overflow(ovf), .underflow(unf), .clr_err(clr_err),
      .err_sticky(err)
   );

   sync_fifo_param #(
      .DATA_W(16), .ADDR_W(3), .AF_THRESH(6), .AE_THRESH(1), .FWFT(1)
   ) dut_fwft (
      .clk(clk), .rst(rst), .flush(f_flush), .push(f_push), .data_in(f_din),
      .pop(f_pop), .data_out(f_dout), .rd_valid(f_rd_valid), .full(f_full),
      .empty(f_empty), .almost_full(f_afull), .almost_empty(f_aempty),
      .count(f_count), .overflow(f_ovf), .underflow(f_unf),
      .clr_err(f_clr_err), .err_sticky(f_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill(input int n, input logic [7:0] base);
      for (int i = 0; i < n; i++) begin
         push = 1'b1;
         din  = base + 8'(i);
         tick();
      end
      push = 1'b0;
   endtask

   task automatic test_reset();
      vectors++; if (count !== 5'd0)  begin errors++; $display("FAIL reset_count act=%0d exp=0", count); end
      vectors++; if (empty !== 1'b1)  begin errors++; $display("FAIL reset_empty act=%b exp=1", empty); end
      vectors++; if (full !== 1'b0)   begin errors++; $display("FAIL reset_full act=%b exp=0", full); end
      vectors++; if (aempty !== 1'b1) begin errors++; $display("FAIL reset_aempty act=%b exp=1", aempty); end
      vectors++; if (afull !== 1'b0)  begin errors++; $display("FAIL reset_afull act=%b exp=0", afull); end
      vectors++; if (dout !== 8'h00)  begin errors++; $display("FAIL reset_dout act=%h exp=00", dout); end
      vectors++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid act=%b exp=0", rd_valid); end
      vectors++; if ({ovf, unf, err} !== 3'b000) begin errors++; $display("FAIL reset_errs act=%b exp=000", {ovf, unf, err}); end
   endtask

   task automatic test_fill_drain();
      for (int i = 1; i <= 16; i++) begin
         push = 1'b1;
         din  = 8'(i);
         tick();
         vectors++; if (count !== 5'(i)) begin errors++; $display("FAIL fill_count[%0d] act=%0d exp=%0d", i, count, i); end
         vectors++; if (afull !== (i >= 14)) begin errors++; $display("FAIL fill_afull[%0d] act=%b exp=%b", i, afull, (i >= 14)); end
         vectors++; if (aempty !== (i <= 2)) begin errors++; $display("FAIL fill_aempty[%0d] act=%b exp=%b", i, aempty, (i <= 2)); end
         vectors++; if (full !== (i == 16)) begin errors++; $display("FAIL fill_full[%0d] act=%b exp=%b", i, full, (i == 16)); end
      end
      push = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         pop = 1'b1;
         tick();
         vectors++; if (dout !== 8'(i)) begin errors++; $display("FAIL drain_data[%0d] act=%h exp=%h", i, dout, 8'(i)); end
         vectors++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL drain_rd_valid[%0d] act=%b exp=1", i, rd_valid); end
         vectors++; if (count !== 5'(16 - i)) begin errors++; $display("FAIL drain_count[%0d] act=%0d exp=%0d", i, count, 16 - i); end
      end
      pop = 1'b0;
      tick();
      vectors++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty act=%b exp=1", empty); end
      vectors++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL idle_rd_valid act=%b exp=0", rd_valid); end
      vectors++; if (dout !== 8'h10) begin errors++; $display("FAIL dout_hold act=%h exp=10", dout); end
   endtask

   task automatic test_full_ops();
      fill(16, 8'h01);
      push = 1'b1; din = 8'hAA; pop = 1'b1;
      tick();
      push = 1'b0; pop = 1'b0;
      vectors++; if (ovf !== 1'b0) begin errors++; $display("FAIL fullpp_ovf act=%b exp=0", ovf); end
      vectors++; if (dout !== 8'h01) begin errors++; $display("FAIL fullpp_data act=%h exp=01", dout); end
      vectors++; if (count !== 5'd16) begin errors++; $display("FAIL fullpp_count act=%0d exp=16", count); end
      push = 1'b1; din = 8'hEE;
      tick();
      push = 1'b0;
      vectors++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_pulse act=%b exp=1", ovf); end
      vectors++; if (err !== 1'b1) begin errors++; $display("FAIL ovf_sticky act=%b exp=1", err); end
      vectors++; if (count !== 5'd16) begin errors++; $display("FAIL ovf_count act=%0d exp=16", count); end
      tick();
      vectors++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear act=%b exp=0", ovf); end
      vectors++; if (err !== 1'b1) begin errors++; $display("FAIL sticky_hold act=%b exp=1", err); end
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      vectors++; if (err !== 1'b0) begin errors++; $display("FAIL clr_err act=%b exp=0", err); end
      // Remaining contents: 02..10 then AA; the rejected EE must not appear.
      for (int i = 0; i < 16; i++) begin
         pop = 1'b1;
         tick();
         vectors++;
         if (dout !== ((i == 15) ? 8'hAA : 8'(i + 2))) begin
            errors++;
            $display("FAIL full_drain[%0d] act=%h exp=%h", i, dout, ((i == 15) ? 8'hAA : 8'(i + 2)));
         end
      end
      pop = 1'b0;
      vectors++; if (empty !== 1'b1) begin errors++; $display("FAIL full_drain_empty act=%b exp=1", empty); end
   endtask

   task automatic test_underflow();
      push = 1'b1; din = 8'h55; pop = 1'b1;
      tick();
      push = 1'b0; pop = 1'b0;
      vectors++; if (unf !== 1'b1) begin errors++; $display("FAIL unf_pulse act=%b exp=1", unf); end
      vectors++; if (count !== 5'd1) begin errors++; $display("FAIL unf_count act=%0d exp=1", count); end
      vectors++; if (err !== 1'b1) begin errors++; $display("FAIL unf_sticky act=%b exp=1", err); end
      vectors++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL unf_rd_valid act=%b exp=0", rd_valid); end
      pop = 1'b1; clr_err = 1'b1;
      tick();
      pop = 1'b0; clr_err = 1'b0;
      vectors++; if (dout !== 8'h55) begin errors++; $display("FAIL unf_data act=%h exp=55", dout); end
      vectors++; if (unf !== 1'b0) begin errors++; $display("FAIL unf_clear act=%b exp=0", unf); end
      vectors++; if (err !== 1'b0) begin errors++; $display("FAIL unf_clr_err act=%b exp=0", err); end
   endtask

   task automatic test_wrap();
      fill(3, 8'hA0);
      for (int k = 0; k < 40; k++) begin
         push = 1'b1; din = 8'hA3 + 8'(k); pop = 1'b1;
         tick();
         vectors++; if (dout !== 8'hA0 + 8'(k)) begin errors++; $display("FAIL wrap_data[%0d] act=%h exp=%h", k, dout, 8'hA0 + 8'(k)); end
         vectors++; if (count !== 5'd3) begin errors++; $display("FAIL wrap_count[%0d] act=%0d exp=3", k, count); end
         vectors++; if ({full, empty} !== 2'b00) begin errors++; $display("FAIL wrap_flags[%0d] act=%b exp=00", k, {full, empty}); end
      end
      push = 1'b0; pop = 1'b0;
      vectors++; if (ovf !== 1'b0 || unf !== 1'b0) begin errors++; $display("FAIL wrap_errs act=%b exp=00", {ovf, unf}); end
   endtask

   task automatic test_flush();
      fill(9, 8'h30);   // 3 entries remain from the wrap test: count 12
      vectors++; if (count !== 5'd12) begin errors++; $display("FAIL preflush_count act=%0d exp=12", count); end
      flush = 1'b1; push = 1'b1; din = 8'h77;
      tick();
      flush = 1'b0; push = 1'b0;
      vectors++; if (count !== 5'd0) begin errors++; $display("FAIL flush_count act=%0d exp=0", count); end
      vectors++; if (empty !== 1'b1) begin errors++; $display("FAIL flush_empty act=%b exp=1", empty); end
      vectors++; if ({ovf, unf, err} !== 3'b000) begin errors++; $display("FAIL flush_errs act=%b exp=000", {ovf, unf, err}); end
      vectors++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL flush_rd_valid act=%b exp=0", rd_valid); end
   endtask

   task automatic test_reset_mid();
      fill(5, 8'h40);
      pop = 1'b1;
      tick();   // one pop so data_out/rd_valid are non-zero
      push = 1'b1; din = 8'h99;
      #2 rst = 1'b1;
      #1;
      vectors++; if (count !== 5'd0) begin errors++; $display("FAIL rstmid_count act=%0d exp=0", count); end
      vectors++; if ({empty, aempty, full, afull} !== 4'b1100) begin errors++; $display("FAIL rstmid_flags act=%b exp=1100", {empty, aempty, full, afull}); end
      vectors++; if (dout !== 8'h00) begin errors++; $display("FAIL rstmid_dout act=%h exp=00", dout); end
      vectors++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rstmid_rd_valid act=%b exp=0", rd_valid); end
      push = 1'b0; pop = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      vectors++; if (empty !== 1'b1) begin errors++; $display("FAIL postrst_empty act=%b exp=1", empty); end
   endtask

   task automatic test_fwft();
      vectors++; if (f_rd_valid !== 1'b0) begin errors++; $display("FAIL fwft_init_valid act=%b exp=0", f_rd_valid); end
      f_push = 1'b1; f_din = 16'hBEEF;
      tick();
      f_push = 1'b0;
      vectors++; if (f_dout !== 16'hBEEF) begin errors++; $display("FAIL fwft_data act=%h exp=beef", f_dout); end
      vectors++; if (f_rd_valid !== 1'b1) begin errors++; $display("FAIL fwft_valid act=%b exp=1", f_rd_valid); end
      vectors++; if (f_count !== 4'd1) begin errors++; $display("FAIL fwft_count act=%0d exp=1", f_count); end
      f_pop = 1'b1;
      tick();
      f_pop = 1'b0;
      vectors++; if (f_rd_valid !== 1'b0) begin errors++; $display("FAIL fwft_pop_valid act=%b exp=0", f_rd_valid); end
      vectors++; if (f_empty !== 1'b1) begin errors++; $display("FAIL fwft_empty act=%b exp=1", f_empty); end
      vectors++; if (f_unf !== 1'b0) begin errors++; $display("FAIL fwft_unf act=%b exp=0", f_unf); end
   endtask

   initial begin
      rst = 1'b1;
      flush = 1'b0; push = 1'b0; pop = 1'b0; clr_err = 1'b0; din = '0;
      f_flush = 1'b0; f_push = 1'b0; f_pop = 1'b0; f_clr_err = 1'b0; f_din = '0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      test_reset();
      test_fill_drain();
      test_full_ops();
      test_underflow();
      test_wrap();
      test_flush();
      test_reset_mid();
      test_fwft();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule : tb_sync_fifo_param
`default_nettype wire
